// File: rtl/serial_mem_loader_pkg.sv
// Shared types and byte constants for the serial memory loader.
package serial_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACCESS,
        ST_SEND
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    localparam logic [2:0] MEM_MODE_NONE = 3'd0;
    localparam logic [2:0] MEM_MODE_WORD = 3'd3;

    // A one-byte response sits in the top byte of the sequencer word.
    function automatic logic [31:0] rsp_word(input logic [7:0] b);
        return {b, 24'h0};
    endfunction

endpackage

// File: rtl/serial_mem_loader_tx.sv
// Sends 1..4 bytes MSB first through the UART, one start_TX per byte,
// with a one-cycle gap after each byte before waiting on TX_ready again.
module loader_tx_sequencer
    import serial_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_count,
    input  logic        TX_ready,
    output logic [7:0]  TX,
    output logic        start_TX,
    output logic        done
);

    tx_state_t   state;
    logic [23:0] rest;
    logic [2:0]  remaining;

    // start_TX follows TX_ready directly so a request never goes out to a busy transmitter.
    assign start_TX = (state == TX_SEND) && TX_ready;
    assign done     = (state == TX_GAP) && (remaining == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TX_IDLE;
            TX        <= 8'h00;
            rest      <= 24'h0;
            remaining <= 3'd0;
        end else begin
            case (state)
                TX_IDLE: if (load) begin
                    TX        <= load_word[31:24];
                    rest      <= load_word[23:0];
                    remaining <= load_count;
                    state     <= TX_SEND;
                end
                TX_SEND: if (TX_ready) begin
                    remaining <= remaining - 3'd1;
                    state     <= TX_GAP;
                end
                TX_GAP: if (remaining == 3'd0) begin
                    state <= TX_IDLE;
                end else begin
                    TX    <= rest[23:16];
                    rest  <= {rest[15:0], 8'h00};
                    state <= TX_SEND;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_mem_loader.sv
// Byte-protocol command engine: decodes P/G/W/R from the UART, drives the
// processor pause and external memory port, and returns ACK/NAK or read data.
module serial_mem_loader
    import serial_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  RX,
    input  logic        hasRX,
    input  logic        rxError,
    output logic [7:0]  TX,
    output logic        start_TX,
    input  logic        TX_ready,
    output logic        pause,
    output logic        externalMemoryControl,
    output logic [31:0] externalAddress,
    output logic [31:0] externalData,
    output logic [2:0]  externalReadMode,
    output logic [2:0]  externalWriteMode,
    input  logic [31:0] externalDataOut
);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] addr_sh;
    logic [31:0] data_sh;
    logic [31:0] idle_cnt;
    logic [31:0] lat_cnt;
    logic        tx_load;
    logic [31:0] tx_word;
    logic [2:0]  tx_count;
    logic        tx_done;
    logic        rx_ok;
    logic        timed_out;
    logic        in_field;

    // A byte that arrives together with a framing error is never used.
    assign rx_ok     = hasRX && !rxError;
    assign in_field  = (state == ST_ADDR) || (state == ST_DATA);
    assign timed_out = (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            byte_cnt              <= 2'd0;
            is_write              <= 1'b0;
            addr_sh               <= 32'h0;
            data_sh               <= 32'h0;
            idle_cnt              <= 32'h0;
            lat_cnt               <= 32'h0;
            tx_load               <= 1'b0;
            tx_word               <= 32'h0;
            tx_count              <= 3'd0;
            pause                 <= 1'b0;
            externalMemoryControl <= 1'b0;
            externalAddress       <= 32'h0;
            externalData          <= 32'h0;
            externalReadMode      <= MEM_MODE_NONE;
            externalWriteMode     <= MEM_MODE_NONE;
        end else begin
            tx_load  <= 1'b0;
            idle_cnt <= (hasRX || !in_field) ? 32'h0 : idle_cnt + 32'h1;
            case (state)
                ST_IDLE: if (rx_ok) begin
                    byte_cnt <= 2'd0;
                    is_write <= (RX == CMD_WRITE);
                    if ((RX == CMD_WRITE || RX == CMD_READ) && pause) begin
                        state <= ST_ADDR;
                    end else begin
                        if (RX == CMD_PAUSE) pause <= 1'b1;
                        if (RX == CMD_GO)    pause <= 1'b0;
                        tx_load  <= 1'b1;
                        tx_count <= 3'd1;
                        tx_word  <= (RX == CMD_PAUSE || RX == CMD_GO) ? rsp_word(RSP_ACK)
                                                                       : rsp_word(RSP_NAK);
                        state    <= ST_SEND;
                    end
                end
                ST_ADDR: if (rxError) begin
                    state <= ST_IDLE;
                end else if (hasRX) begin
                    addr_sh  <= {addr_sh[23:0], RX};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (is_write) begin
                            state <= ST_DATA;
                        end else begin
                            externalAddress       <= {addr_sh[23:0], RX};
                            externalMemoryControl <= 1'b1;
                            externalReadMode      <= MEM_MODE_WORD;
                            lat_cnt               <= 32'h0;
                            state                 <= ST_ACCESS;
                        end
                    end
                end else if (timed_out) begin
                    state <= ST_IDLE;
                end
                ST_DATA: if (rxError) begin
                    state <= ST_IDLE;
                end else if (hasRX) begin
                    data_sh  <= {data_sh[23:0], RX};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        externalAddress       <= addr_sh;
                        externalData          <= {data_sh[23:0], RX};
                        externalMemoryControl <= 1'b1;
                        externalWriteMode     <= MEM_MODE_WORD;
                        state                 <= ST_ACCESS;
                    end
                end else if (timed_out) begin
                    state <= ST_IDLE;
                end
                ST_ACCESS: if (is_write) begin
                    externalMemoryControl <= 1'b0;
                    externalWriteMode     <= MEM_MODE_NONE;
                    tx_load               <= 1'b1;
                    tx_count              <= 3'd1;
                    tx_word               <= rsp_word(RSP_ACK);
                    state                 <= ST_SEND;
                end else if (lat_cnt == 32'(READ_LATENCY)) begin
                    // Read data is valid on the last held cycle; it goes straight to the TX shifter.
                    externalMemoryControl <= 1'b0;
                    externalReadMode      <= MEM_MODE_NONE;
                    tx_load               <= 1'b1;
                    tx_count              <= 3'd4;
                    tx_word               <= externalDataOut;
                    state                 <= ST_SEND;
                end else begin
                    lat_cnt <= lat_cnt + 32'h1;
                end
                ST_SEND: if (tx_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    loader_tx_sequencer u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_word (tx_word),
        .load_count(tx_count),
        .TX_ready  (TX_ready),
        .TX        (TX),
        .start_TX  (start_TX),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_serial_mem_loader.sv
// Directed bench: command-level model of the loader plus per-cycle output checking.
module tb_serial_mem_loader;

    localparam int TO = 16;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  RX = 8'h00;
    logic        hasRX = 1'b0;
    logic        rxError = 1'b0;
    logic [7:0]  TX;
    logic        start_TX;
    logic        TX_ready = 1'b1;
    logic        pause;
    logic        externalMemoryControl;
    logic [31:0] externalAddress;
    logic [31:0] externalData;
    logic [2:0]  externalReadMode;
    logic [2:0]  externalWriteMode;
    logic [31:0] externalDataOut = 32'h0;

    always #5 clk = ~clk;

    serial_mem_loader #(.TIMEOUT_CYCLES(TO), .READ_LATENCY(RL)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .RX                   (RX),
        .hasRX                (hasRX),
        .rxError              (rxError),
        .TX                   (TX),
        .start_TX             (start_TX),
        .TX_ready             (TX_ready),
        .pause                (pause),
        .externalMemoryControl(externalMemoryControl),
        .externalAddress      (externalAddress),
        .externalData         (externalData),
        .externalReadMode     (externalReadMode),
        .externalWriteMode    (externalWriteMode),
        .externalDataOut      (externalDataOut)
    );

    int total = 0;
    int bad = 0;

    // model state
    logic        exp_pause = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] mem_m[logic [31:0]];
    logic [7:0]  cmd[$];

    // bench-side memory and observation logs
    logic [31:0] mem_b[logic [31:0]];
    logic [7:0]  tx_log[$];
    int          n_start = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s act=%h req=none", name, act);
    endtask

    // Processor memory: one register stage gives READ_LATENCY=1.
    always @(posedge clk) begin
        if (externalMemoryControl && externalWriteMode == 3'd3)
            mem_b[externalAddress] = externalData;
        if (externalMemoryControl && externalReadMode == 3'd3)
            externalDataOut <= mem_b.exists(externalAddress) ? mem_b[externalAddress] : 32'h0;
        else
            externalDataOut <= 32'h0;
    end

    // Compare process; also plays the UART transmitter (busy 3 cycles per byte).
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            busy = 0;
            TX_ready = 1'b1;
        end else begin
            chk("pause", {31'h0, pause}, {31'h0, exp_pause});
            chk("ctrl_vs_mode", {31'h0, externalMemoryControl},
                {31'h0, (externalReadMode != 3'd0) || (externalWriteMode != 3'd0)});
            if (start_TX) begin
                n_start++;
                tx_log.push_back(TX);
                chk("tx_ready_at_start", {31'h0, TX_ready}, 32'h1);
                if (exp_tx.size() == 0) fail_now("unexpected_tx", {24'h0, TX});
                else chk("tx_byte", {24'h0, TX}, {24'h0, exp_tx.pop_front()});
            end
            if (externalWriteMode != 3'd0) begin
                wr_cycles++;
                chk("wr_ctrl", {25'h0, externalMemoryControl, externalWriteMode, externalReadMode},
                    {25'h0, 1'b1, 3'd3, 3'd0});
                if (exp_wr.size() == 0) fail_now("unexpected_write", externalAddress);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", externalAddress, e[63:32]);
                    chk("wr_data", externalData, e[31:0]);
                end
            end
            if (externalReadMode != 3'd0) begin
                rd_cycles++;
                chk("rd_ctrl", {25'h0, externalMemoryControl, externalWriteMode, externalReadMode},
                    {25'h0, 1'b1, 3'd0, 3'd3});
            end
            if (start_TX) busy = 3;
            else if (busy > 0) busy--;
            TX_ready = (busy == 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(posedge clk); #1;
        RX = b; hasRX = 1'b1; rxError = err;
        @(posedge clk); #1;
        hasRX = 1'b0; rxError = 1'b0;
    endtask

    task automatic send_cmd();
        foreach (cmd[i]) send_byte(cmd[i], 1'b0);
    endtask

    // Command-level model: what a complete command must produce.
    task automatic model();
        logic [31:0] a, d;
        case (cmd[0])
            8'h50: begin exp_pause = 1'b1; exp_tx.push_back(8'h06); end
            8'h47: begin exp_pause = 1'b0; exp_tx.push_back(8'h06); end
            8'h57: if (!exp_pause) exp_tx.push_back(8'h15);
                   else begin
                       a = {cmd[1], cmd[2], cmd[3], cmd[4]};
                       d = {cmd[5], cmd[6], cmd[7], cmd[8]};
                       mem_m[a] = d;
                       exp_wr.push_back({a, d});
                       exp_tx.push_back(8'h06);
                   end
            8'h52: if (!exp_pause) exp_tx.push_back(8'h15);
                   else begin
                       a = {cmd[1], cmd[2], cmd[3], cmd[4]};
                       d = mem_m.exists(a) ? mem_m[a] : 32'h0;
                       for (int k = 3; k >= 0; k--) exp_tx.push_back(d[k*8 +: 8]);
                   end
            default: exp_tx.push_back(8'h15);
        endcase
    endtask

    task automatic run_cmd();
        send_cmd();
        model();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) fail_now({name, "_timeout"}, exp_tx.size());
        else begin
            total++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_tx"}, {24'h0, TX}, 32'h0);
        chk({name, "_start"}, {31'h0, start_TX}, 32'h0);
        chk({name, "_pause"}, {31'h0, pause}, 32'h0);
        chk({name, "_ctrl"}, {31'h0, externalMemoryControl}, 32'h0);
        chk({name, "_addr"}, externalAddress, 32'h0);
        chk({name, "_data"}, externalData, 32'h0);
        chk({name, "_rmode"}, {29'h0, externalReadMode}, 32'h0);
        chk({name, "_wmode"}, {29'h0, externalWriteMode}, 32'h0);
    endtask

    initial begin
        int n0, k, w0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        cmd = {8'h50}; run_cmd(); wait_done("P");
        chk("pause_after_P", {31'h0, pause}, 32'h1);
        cmd = {8'h47}; run_cmd(); wait_done("G");
        chk("pause_after_G", {31'h0, pause}, 32'h0);
        chk("ack_bytes", {16'h0, tx_log[0], tx_log[1]}, 32'h0606);

        cmd = {8'h50}; run_cmd(); wait_done("P2");
        cmd = {8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_cmd(); wait_done("W");
        chk("wr_cycles", wr_cycles, 32'd1);
        chk("mem_100", mem_b.exists(32'h100) ? mem_b[32'h100] : 32'h0, 32'hDEADBEEF);

        tx_log.delete(); rd_cycles = 0;
        cmd = {8'h52, 8'h00, 8'h00, 8'h01, 8'h00}; run_cmd(); wait_done("R");
        chk("rd_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hDEADBEEF);
        chk("rd_start_count", tx_log.size(), 32'd4);
        chk("rd_cycles", rd_cycles, 32'd2);

        // gap of TIMEOUT_CYCLES-3 idle clocks must not abort
        send_byte(8'h57, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        repeat (TO - 3) @(posedge clk);
        cmd = {8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78}; send_cmd();
        cmd = {8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78}; model();
        wait_done("W_slow");
        cmd = {8'h52, 8'h00, 8'h00, 8'h00, 8'h04}; run_cmd(); wait_done("R_slow");

        tx_log.delete();
        cmd = {8'h47}; run_cmd(); wait_done("G2");
        cmd = {8'h57}; run_cmd(); wait_done("W_nopause");
        cmd = {8'h52}; run_cmd(); wait_done("R_nopause");
        cmd = {8'h33}; run_cmd(); wait_done("unknown");
        chk("nak_bytes", {8'h0, tx_log[1], tx_log[2], tx_log[3]}, 32'h151515);

        // timeout abort: no response, no write, next command handled normally
        cmd = {8'h50}; run_cmd(); wait_done("P3");
        w0 = wr_cycles; n0 = n_start;
        send_byte(8'h57, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        repeat (TO + 5) @(posedge clk);
        chk("timeout_no_tx", n_start, n0);
        chk("timeout_no_write", wr_cycles, w0);
        cmd = {8'h50}; run_cmd(); wait_done("P_after_timeout");

        // framing error after two address bytes aborts silently
        n0 = n_start;
        send_byte(8'h52, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        @(posedge clk); #1; rxError = 1'b1; @(posedge clk); #1; rxError = 1'b0;
        repeat (5) @(posedge clk);
        chk("rxerr_no_tx", n_start, n0);
        cmd = {8'h47}; run_cmd(); wait_done("G_after_rxerr");

        // byte carrying a framing error is discarded
        send_byte(8'h50, 1'b1);
        repeat (10) @(posedge clk); #1;
        chk("err_byte_discarded", {31'h0, pause}, 32'h0);

        // reset in the middle of read data return
        cmd = {8'h50}; run_cmd(); wait_done("P4");
        n0 = n_start;
        cmd = {8'h52, 8'h00, 8'h00, 8'h01, 8'h00}; run_cmd();
        k = 0;
        while (n_start == n0 && k < 100) begin @(posedge clk); k++; end
        chk("rd_first_byte_seen", n_start, n0 + 1);
        @(posedge clk); #1;
        rst = 1'b1; exp_pause = 1'b0; exp_tx.delete(); exp_wr.delete();
        @(posedge clk); #1;
        chk_idle_outputs("midreset");
        rst = 1'b0;
        n0 = n_start;
        repeat (40) @(posedge clk);
        chk("no_tx_after_reset", n_start, n0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
